// File: rtl/gpio_pulse_shaper.sv
// Synchronises the PIO level, detects rising edges and turns each one into a
// fixed-width pulse followed by a hold-off gap, with a one-deep edge queue.
module gpio_pulse_shaper #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_WIDTH = 16,
    parameter int HOLDOFF     = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gpio_in,
    input  logic             clr_overrun,
    output logic             pulse_out,
    output logic             busy,
    output logic             pending,
    output logic             overrun,
    output logic [CNT_W-1:0] pulse_count
);

    localparam int TW = 16;
    localparam logic [TW-1:0] PW_LOAD = TW'(PULSE_WIDTH - 1);
    localparam logic [TW-1:0] HO_LOAD = (HOLDOFF > 0) ? TW'(HOLDOFF - 1) : '0;
    localparam bit HAS_HOLDOFF = (HOLDOFF > 0);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLDOFF} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   rise, timer_done, start_pulse, absorb;

    assign rise       = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign timer_done = (timer_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            edge_q    <= sync_q[SYNC_STAGES-1];
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    // A rise landing on the final cycle is handled like a queued edge: the next
    // pulse starts at once instead of being parked in pending while IDLE.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pending_d   = pending_q;
        count_d     = count_q;
        overrun_d   = overrun_q & ~clr_overrun;
        start_pulse = 1'b0;
        absorb      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) start_pulse = 1'b1;
            end
            S_PULSE: begin
                if (!timer_done) begin
                    timer_d = timer_q - 1'b1;
                    absorb  = 1'b1;
                end else if (HAS_HOLDOFF) begin
                    state_d = S_HOLDOFF;
                    timer_d = HO_LOAD;
                    absorb  = 1'b1;
                end else if (pending_q || rise) begin
                    start_pulse = 1'b1;
                    pending_d   = pending_q & rise;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLDOFF: begin
                if (!timer_done) begin
                    timer_d = timer_q - 1'b1;
                    absorb  = 1'b1;
                end else if (pending_q || rise) begin
                    start_pulse = 1'b1;
                    pending_d   = pending_q & rise;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (absorb && rise) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        if (start_pulse) begin
            state_d = S_PULSE;
            timer_d = PW_LOAD;
            count_d = count_q + 1'b1;
        end
    end

    assign pulse_out   = (state_q == S_PULSE);
    assign busy        = (state_q != S_IDLE);
    assign pending     = pending_q;
    assign overrun     = overrun_q;
    assign pulse_count = count_q;

endmodule

// File: tb/tb_gpio_pulse_shaper.sv
// Directed bench for gpio_pulse_shaper: default build plus two short-pulse,
// zero-hold-off builds; pulse runs are checked against a queue of expected runs.
module tb_gpio_pulse_shaper;

    logic        clk;
    logic        reset;
    logic        gpio_a, gpio_b, clr_a, clr_bc;
    logic        pulse_a, busy_a, pend_a, ovr_a;
    logic        pulse_b, busy_b, pend_b, ovr_b;
    logic        pulse_c, busy_c, pend_c, ovr_c;
    logic [15:0] cnt_a, cnt_c;
    logic [1:0]  cnt_b;

    gpio_pulse_shaper dut_a (
        .clk(clk), .reset(reset), .gpio_in(gpio_a), .clr_overrun(clr_a),
        .pulse_out(pulse_a), .busy(busy_a), .pending(pend_a), .overrun(ovr_a),
        .pulse_count(cnt_a));

    gpio_pulse_shaper #(.SYNC_STAGES(2), .PULSE_WIDTH(1), .HOLDOFF(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .gpio_in(gpio_b), .clr_overrun(clr_bc),
        .pulse_out(pulse_b), .busy(busy_b), .pending(pend_b), .overrun(ovr_b),
        .pulse_count(cnt_b));

    gpio_pulse_shaper #(.SYNC_STAGES(2), .PULSE_WIDTH(3), .HOLDOFF(0), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .gpio_in(gpio_b), .clr_overrun(clr_bc),
        .pulse_out(pulse_c), .busy(busy_c), .pending(pend_c), .overrun(ovr_c),
        .pulse_count(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int start;
        int len;
        int cnt;
    } exp_t;

    exp_t eq0[$];
    exp_t eq1[$];
    exp_t eq2[$];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   in_run    [3];
    int   run_start [3];
    int   run_cnt   [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int inst, input int start, input int len, input int cnt);
        exp_t e;
        e.start = start;
        e.len   = len;
        e.cnt   = cnt;
        case (inst)
            0:       eq0.push_back(e);
            1:       eq1.push_back(e);
            default: eq2.push_back(e);
        endcase
    endtask

    task automatic check_run(input int inst, input int start, input int len, input int cnt);
        exp_t e;
        int   sz;
        sz = (inst == 0) ? eq0.size() : (inst == 1) ? eq1.size() : eq2.size();
        chk($sformatf("dut%0d_run_expected", inst), 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            case (inst)
                0:       e = eq0.pop_front();
                1:       e = eq1.pop_front();
                default: e = eq2.pop_front();
            endcase
            chk($sformatf("dut%0d_run_start", inst), start, e.start);
            chk($sformatf("dut%0d_run_len", inst), len, e.len);
            chk($sformatf("dut%0d_run_count", inst), cnt, e.cnt);
        end
    endtask

    // Advance one clock, sample 1 time unit later and collect pulse runs.
    task automatic tick();
        logic pv [3];
        int   cv [3];
        @(posedge clk);
        #1;
        cyc++;
        pv[0] = pulse_a; cv[0] = int'(cnt_a);
        pv[1] = pulse_b; cv[1] = int'(cnt_b);
        pv[2] = pulse_c; cv[2] = int'(cnt_c);
        for (int i = 0; i < 3; i++) begin
            if (pv[i] && !in_run[i]) begin
                in_run[i]    = 1'b1;
                run_start[i] = cyc;
                run_cnt[i]   = cv[i];
            end else if (!pv[i] && in_run[i]) begin
                in_run[i] = 1'b0;
                check_run(i, run_start[i], cyc - run_start[i], run_cnt[i]);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int t0, t1, t3, tr, nbusy;
        for (int i = 0; i < 3; i++) in_run[i] = 1'b0;
        reset  = 1'b1;
        gpio_a = 1'b0;
        gpio_b = 1'b0;
        clr_a  = 1'b0;
        clr_bc = 1'b0;
        #1;
        chk("reset_outputs", {pulse_a, busy_a, pend_a, ovr_a}, 32'd0);
        chk("reset_count", cnt_a, 32'd0);
        ticks(3);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_outputs", {pulse_a, busy_a, pend_a, ovr_a}, 32'd0);
            chk("idle_count", cnt_a, 32'd0);
        end

        // Single edge, level held high afterwards.
        t0 = cyc;
        gpio_a = 1'b1;
        push_exp(0, t0 + 3, 16, 1);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy_a) nbusy++;
        end
        chk("busy_cycles", nbusy, 32'd24);
        chk("count_after_one", cnt_a, 32'd1);
        chk("no_extra_pulse", eq0.size(), 32'd0);

        // Second edge during PULSE is queued behind the hold-off.
        gpio_a = 1'b0;
        ticks(4);
        t1 = cyc;
        gpio_a = 1'b1;
        push_exp(0, t1 + 3, 16, 2);
        ticks(5);
        gpio_a = 1'b0;
        ticks(4);
        gpio_a = 1'b1;
        push_exp(0, t1 + 3 + 16 + 8, 16, 3);
        ticks(5);
        chk("queued_pending", pend_a, 32'd1);
        chk("queued_no_overrun", ovr_a, 32'd0);
        ticks(40);
        chk("count_after_queue", cnt_a, 32'd3);
        chk("pending_drained", pend_a, 32'd0);
        chk("overrun_still_clear", ovr_a, 32'd0);

        // Three edges in one pulse window, then overrun clear behaviour.
        t3 = cyc;
        gpio_a = 1'b0;
        ticks(2);
        gpio_a = 1'b1;
        push_exp(0, t3 + 5, 16, 4);
        ticks(2);
        gpio_a = 1'b0;
        ticks(2);
        gpio_a = 1'b1;
        push_exp(0, t3 + 5 + 16 + 8, 16, 5);
        ticks(2);
        gpio_a = 1'b0;
        ticks(2);
        gpio_a = 1'b1;
        ticks(4);
        chk("triple_pending", pend_a, 32'd1);
        chk("triple_overrun", ovr_a, 32'd1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("overrun_cleared", ovr_a, 32'd0);
        chk("pending_kept_on_clear", pend_a, 32'd1);
        gpio_a = 1'b0;
        ticks(2);
        gpio_a = 1'b1;
        ticks(2);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("overrun_set_wins", ovr_a, 32'd1);
        chk("pulse_still_active", pulse_a, 32'd1);
        ticks(40);
        chk("count_after_triple", cnt_a, 32'd5);
        chk("pending_after_triple", pend_a, 32'd0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("overrun_cleared_idle", ovr_a, 32'd0);

        // Asynchronous reset in the middle of a pulse with an edge queued.
        gpio_a = 1'b0;
        ticks(2);
        gpio_a = 1'b1;
        ticks(5);
        gpio_a = 1'b0;
        ticks(2);
        gpio_a = 1'b1;
        ticks(5);
        chk("pre_reset_pulse", pulse_a, 32'd1);
        chk("pre_reset_pending", pend_a, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {pulse_a, busy_a, pend_a, ovr_a}, 32'd0);
        chk("async_reset_count", cnt_a, 32'd0);
        in_run[0] = 1'b0;
        ticks(3);
        tr = cyc;
        reset = 1'b0;
        push_exp(0, tr + 3, 16, 1);
        ticks(40);
        chk("count_after_reset", cnt_a, 32'd1);
        chk("pending_after_reset", pend_a, 32'd0);

        // Narrow pulses, zero hold-off: wrap of a 2-bit counter and merged runs.
        t0 = cyc;
        gpio_b = 1'b1;
        tick();
        gpio_b = 1'b0;
        tick();
        gpio_b = 1'b1;
        push_exp(1, t0 + 3, 1, 1);
        push_exp(1, t0 + 5, 1, 2);
        push_exp(2, t0 + 3, 6, 1);
        ticks(12);
        for (int k = 0; k < 3; k++) begin
            gpio_b = 1'b0;
            ticks(3);
            t1 = cyc;
            gpio_b = 1'b1;
            push_exp(1, t1 + 3, 1, (3 + k) % 4);
            push_exp(2, t1 + 3, 3, 3 + k);
            ticks(10);
        end
        chk("narrow_count_wrapped", cnt_b, 32'd1);
        chk("narrow_no_overrun", ovr_b, 32'd0);
        chk("merged_count", cnt_c, 32'd5);
        chk("merged_pending", pend_c, 32'd0);
        chk("merged_no_overrun", ovr_c, 32'd0);

        chk("outstanding_a", eq0.size(), 32'd0);
        chk("outstanding_b", eq1.size(), 32'd0);
        chk("outstanding_c", eq2.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
